// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite compositor.
// Optional cold tint is enabled by defining COLD_TINT_EN.
package sprite_pkg;

    localparam int COLOR_W = 12;
    localparam logic [COLOR_W-1:0] KEY_COLOR_DEF = 12'h428;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    function automatic int clog2(input int v);
        int r;
        int p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Halve red and fold it into blue, saturating blue at 15.
    function automatic rgb444_t tint(input rgb444_t c);
        rgb444_t    t;
        logic [4:0] bs;
        bs  = {1'b0, c.b} + {2'b00, c.r[3:1]};
        t.r = {1'b0, c.r[3:1]};
        t.g = c.g;
        t.b = bs[4] ? 4'hF : bs[3:0];
        return t;
    endfunction

endpackage

// File: rtl/sprite_channel.sv
// One sprite: shadow registers, animation counters, hit test,
// ROM address generation and hit-flag alignment with ROM data.
module sprite_channel
    import sprite_pkg::*;
#(
    parameter int SPR_W      = 47,
    parameter int SPR_H      = 41,
    parameter int NUM_FRAMES = 6,
    parameter int FRAME_HOLD = 15,
    parameter int ADDR_W     = 14,
    parameter int FR_W       = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              frame_start,
    input  logic [9:0]        col_addr,
    input  logic [8:0]        row_addr,
    input  logic [9:0]        x_in,
    input  logic [8:0]        y_in,
    input  logic              en_in,
    input  logic              anim_in,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [FR_W-1:0]   cur_frame,
    output logic              hit_dly
);

    localparam int HOLD_W = (clog2(FRAME_HOLD) < 1) ? 1 : clog2(FRAME_HOLD);

    logic [9:0]        x_q, x_d;
    logic [8:0]        y_q, y_d;
    logic              en_q, en_d;
    logic              anim_q, anim_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [FR_W-1:0]   frame_q, frame_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              hit1_q, hit1_d;
    logic              hit2_q, hit2_d;

    logic [10:0] x_end;
    logic [9:0]  y_end;
    logic [9:0]  dx;
    logic [8:0]  dy;

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        en_d    = en_q;
        anim_d  = anim_q;
        hold_d  = hold_q;
        frame_d = frame_q;
        if (frame_start) begin
            x_d    = x_in;
            y_d    = y_in;
            en_d   = en_in;
            anim_d = anim_in;
            // Counters act on the shadow value from before this edge.
            if (!anim_q) begin
                hold_d  = '0;
                frame_d = '0;
            end else if (hold_q == HOLD_W'(FRAME_HOLD - 1)) begin
                hold_d  = '0;
                frame_d = (frame_q == FR_W'(NUM_FRAMES - 1)) ?
                          '0 : frame_q + 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_comb begin
        x_end  = {1'b0, x_q} + 11'(SPR_W);
        y_end  = {1'b0, y_q} + 10'(SPR_H);
        dx     = col_addr - x_q;
        dy     = row_addr - y_q;
        hit1_d = en_q
              && (col_addr >= x_q) && ({1'b0, col_addr} < x_end)
              && (row_addr >= y_q) && ({1'b0, row_addr} < y_end);
        addr_d = '0;
        if (hit1_d) begin
            addr_d = ADDR_W'(frame_q) * ADDR_W'(SPR_W * SPR_H)
                   + ADDR_W'(dy) * ADDR_W'(SPR_W)
                   + ADDR_W'(dx);
        end
        hit2_d = hit1_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_q     <= '0;
            y_q     <= '0;
            en_q    <= 1'b0;
            anim_q  <= 1'b0;
            hold_q  <= '0;
            frame_q <= '0;
            addr_q  <= '0;
            hit1_q  <= 1'b0;
            hit2_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            en_q    <= en_d;
            anim_q  <= anim_d;
            hold_q  <= hold_d;
            frame_q <= frame_d;
            addr_q  <= addr_d;
            hit1_q  <= hit1_d;
            hit2_q  <= hit2_d;
        end
    end

    assign rom_addr  = addr_q;
    assign cur_frame = frame_q;
    assign hit_dly   = hit2_q;

endmodule

// File: rtl/sprite_compositor.sv
// Multi-sprite overlay over background, fixed 3-cycle latency.
// Define COLD_TINT_EN to add the tint_en port and cold tint stage.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int NUM_SPR    = 4,
    parameter int SPR_W      = 47,
    parameter int SPR_H      = 41,
    parameter int NUM_FRAMES = 6,
    parameter int FRAME_HOLD = 15,
    parameter logic [COLOR_W-1:0] KEY_COLOR = KEY_COLOR_DEF,
    parameter int ADDR_W     = clog2(SPR_W * SPR_H * NUM_FRAMES),
    parameter int FR_W       = (clog2(NUM_FRAMES) < 1) ? 1 : clog2(NUM_FRAMES)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      pix_valid,
    input  logic [9:0]                col_addr,
    input  logic [8:0]                row_addr,
    input  logic                      frame_start,
    input  logic [COLOR_W-1:0]        bg_data,
    input  logic [NUM_SPR*10-1:0]     spr_x,
    input  logic [NUM_SPR*9-1:0]      spr_y,
    input  logic [NUM_SPR-1:0]        spr_en,
    input  logic [NUM_SPR-1:0]        spr_anim_en,
`ifdef COLD_TINT_EN
    input  logic                      tint_en,
`endif
    output logic [NUM_SPR*ADDR_W-1:0] rom_addr,
    input  logic [NUM_SPR*12-1:0]     rom_data,
    output logic [NUM_SPR*FR_W-1:0]   cur_frame,
    output logic [COLOR_W-1:0]        pix_out,
    output logic                      pix_out_valid
);

    logic [NUM_SPR-1:0] hit_dly;

    for (genvar g = 0; g < NUM_SPR; g++) begin : g_ch
        sprite_channel #(
            .SPR_W      (SPR_W),
            .SPR_H      (SPR_H),
            .NUM_FRAMES (NUM_FRAMES),
            .FRAME_HOLD (FRAME_HOLD),
            .ADDR_W     (ADDR_W),
            .FR_W       (FR_W)
        ) u_ch (
            .clk         (clk),
            .rstn        (rstn),
            .frame_start (frame_start),
            .col_addr    (col_addr),
            .row_addr    (row_addr),
            .x_in        (spr_x[g*10 +: 10]),
            .y_in        (spr_y[g*9 +: 9]),
            .en_in       (spr_en[g]),
            .anim_in     (spr_anim_en[g]),
            .rom_addr    (rom_addr[g*ADDR_W +: ADDR_W]),
            .cur_frame   (cur_frame[g*FR_W +: FR_W]),
            .hit_dly     (hit_dly[g])
        );
    end

    logic               vld1_q, vld1_d;
    logic               vld2_q, vld2_d;
    logic [COLOR_W-1:0] bg1_q, bg1_d;
    logic [COLOR_W-1:0] bg2_q, bg2_d;
    logic [COLOR_W-1:0] pix_q, pix_d;
    logic               pv_q, pv_d;
    logic [COLOR_W-1:0] comp;

    always_comb begin
        vld1_d = pix_valid;
        bg1_d  = bg_data;
        vld2_d = vld1_q;
        bg2_d  = bg1_q;
        comp   = bg2_q;
        // Walk downwards so the lowest-index opaque hit wins.
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (hit_dly[i] && (rom_data[i*12 +: 12] != KEY_COLOR)) begin
                comp = rom_data[i*12 +: 12];
            end
        end
`ifdef COLD_TINT_EN
        if (tint_en) begin
            comp = tint(comp);
        end
`endif
        pix_d = vld2_q ? comp : '0;
        pv_d  = vld2_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld1_q <= 1'b0;
            vld2_q <= 1'b0;
            bg1_q  <= '0;
            bg2_q  <= '0;
            pix_q  <= '0;
            pv_q   <= 1'b0;
        end else begin
            vld1_q <= vld1_d;
            vld2_q <= vld2_d;
            bg1_q  <= bg1_d;
            bg2_q  <= bg2_d;
            pix_q  <= pix_d;
            pv_q   <= pv_d;
        end
    end

    assign pix_out       = pix_q;
    assign pix_out_valid = pv_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed table-driven bench for sprite_compositor (FRAME_HOLD=2).
module tb_sprite_compositor;

    localparam int NS = 4;
    localparam int AW = 14;
    localparam int FW = 3;
`ifdef COLD_TINT_EN
    localparam logic [11:0] EXP_EDGE = 12'h74F;
`else
    localparam logic [11:0] EXP_EDGE = 12'hF48;
`endif

    logic             clk;
    logic             rstn;
    logic             pv;
    logic [9:0]       col;
    logic [8:0]       row;
    logic             frame_start;
    logic [11:0]      bg;
    logic [NS*10-1:0] spr_x;
    logic [NS*9-1:0]  spr_y;
    logic [NS-1:0]    spr_en;
    logic [NS-1:0]    spr_anim_en;
    logic             tint_en;
    logic [NS*AW-1:0] rom_addr;
    logic [NS*12-1:0] rom_data;
    logic [NS*FW-1:0] cur_frame;
    logic [11:0]      pix_out;
    logic             pix_out_valid;

    sprite_compositor #(.FRAME_HOLD(2)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .pix_valid     (pv),
        .col_addr      (col),
        .row_addr      (row),
        .frame_start   (frame_start),
        .bg_data       (bg),
        .spr_x         (spr_x),
        .spr_y         (spr_y),
        .spr_en        (spr_en),
        .spr_anim_en   (spr_anim_en),
`ifdef COLD_TINT_EN
        .tint_en       (tint_en),
`endif
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .cur_frame     (cur_frame),
        .pix_out       (pix_out),
        .pix_out_valid (pix_out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] mem [NS][16384];

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            rom_data[i*12 +: 12] <= mem[i][rom_addr[i*AW +: AW]];
        end
    end

    typedef struct {
        logic        pv;
        logic [9:0]  col;
        logic [8:0]  row;
        logic [11:0] bg;
        logic [13:0] addr;
        logic [11:0] pix;
    } vec_t;

    vec_t vq[$];
    int   total;
    int   bad;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic add(input logic p, input int c, input int r,
                       input logic [11:0] b, input int a,
                       input logic [11:0] x);
        vec_t v;
        v.pv   = p;
        v.col  = 10'(c);
        v.row  = 9'(r);
        v.bg   = b;
        v.addr = 14'(a);
        v.pix  = x;
        vq.push_back(v);
    endtask

    // Stream back-to-back: address one edge later, pixel three edges later.
    task automatic run_q(input string tag);
        int n;
        n = vq.size();
        for (int k = 0; k < n + 3; k++) begin
            @(negedge clk);
            if (k >= 1 && k - 1 < n)
                chk($sformatf("%s_addr%0d", tag, k - 1),
                    32'(rom_addr[AW-1:0]), 32'(vq[k-1].addr));
            if (k >= 3) begin
                chk($sformatf("%s_pix%0d", tag, k - 3),
                    32'(pix_out), 32'(vq[k-3].pix));
                chk($sformatf("%s_vld%0d", tag, k - 3),
                    32'(pix_out_valid), 32'(vq[k-3].pv));
            end
            if (k < n) begin
                pv  = vq[k].pv;
                col = vq[k].col;
                row = vq[k].row;
                bg  = vq[k].bg;
            end else begin
                pv = 1'b0;
            end
        end
        vq.delete();
    endtask

    task automatic pulse(input bit px);
        @(negedge clk);
        frame_start = 1'b1;
        if (px) begin
            pv  = 1'b1;
            col = 10'd110;
            row = 9'd55;
            bg  = 12'h456;
        end
        @(negedge clk);
        frame_start = 1'b0;
        pv = 1'b0;
    endtask

    int exp_fr[12] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 0};

    initial begin
        total       = 0;
        bad         = 0;
        rstn        = 1'b0;
        pv          = 1'b0;
        col         = '0;
        row         = '0;
        frame_start = 1'b0;
        bg          = '0;
        spr_x       = '0;
        spr_y       = '0;
        spr_en      = '0;
        spr_anim_en = '0;
        tint_en     = 1'b0;
        for (int i = 0; i < NS; i++)
            for (int a = 0; a < 16384; a++)
                mem[i][a] = 12'h428;
        mem[0][245]  = 12'hABC;
        mem[0][730]  = 12'h111;
        mem[1][240]  = 12'h222;
        mem[1][288]  = 12'h333;
        mem[0][19]   = 12'hF48;

        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_pix", 32'(pix_out), 32'h0);
        chk("rst_vld", 32'(pix_out_valid), 32'h0);
        chk("rst_frame", 32'(cur_frame), 32'h0);

        // Sprite 0 at (100,50), sprite 1 at (120,60) overlapping it.
        spr_x[0 +: 10] = 10'd100;
        spr_y[0 +: 9]  = 9'd50;
        spr_x[10 +: 10] = 10'd120;
        spr_y[9 +: 9]   = 9'd60;
        spr_en = 4'b0011;
        pulse(1'b0);

        add(1, 100, 50, 12'h123, 0,    12'h123);
        add(1, 110, 55, 12'h456, 245,  12'hABC);
        add(1, 146, 90, 12'h789, 1926, 12'h789);
        add(1, 147, 90, 12'h9AB, 0,    12'h9AB);
        add(1, 125, 65, 12'h0F0, 730,  12'h111);
        add(1, 126, 66, 12'h0F0, 778,  12'h333);
        add(0, 110, 55, 12'h456, 245,  12'h000);
        add(1, 99,  50, 12'hCDE, 0,    12'hCDE);
        add(1, 100, 91, 12'h321, 0,    12'h321);
        add(1, 100, 49, 12'h654, 0,    12'h654);
        run_q("comp");

        // Shadowing: position change without frame_start is ignored.
        spr_x[0 +: 10] = 10'd200;
        add(1, 110, 55, 12'h456, 245, 12'hABC);
        run_q("shadow");

        spr_x[0 +: 10] = 10'd100;
        spr_anim_en = 4'b0001;
        pulse(1'b0);
        chk("anim_prime", 32'(cur_frame[0 +: FW]), 32'h0);
        for (int k = 0; k < 12; k++) begin
            pulse(k == 2);
            if (k == 2)
                chk("fs_with_pix_addr", 32'(rom_addr[AW-1:0]), 32'd2172);
            chk($sformatf("anim_fr%0d", k + 1),
                32'(cur_frame[0 +: FW]), 32'(exp_fr[k]));
            if (k == 1) begin
                add(1, 100, 50, 12'h777, 1927, 12'h777);
                run_q("frame1");
            end
        end
        chk("static_fr1", 32'(cur_frame[FW +: FW]), 32'h0);

        // Asynchronous reset in the middle of a pixel stream.
        @(negedge clk);
        pv  = 1'b1;
        col = 10'd110;
        row = 9'd55;
        bg  = 12'h456;
        repeat (3) @(negedge clk);
        chk("pre_rst_vld", 32'(pix_out_valid), 32'h1);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(pix_out_valid), 32'h0);
        chk("mid_rst_pix", 32'(pix_out), 32'h0);
        chk("mid_rst_frame", 32'(cur_frame), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        bg   = 12'h5A5;
        @(negedge clk);
        chk("rel_vld1", 32'(pix_out_valid), 32'h0);
        @(negedge clk);
        chk("rel_vld2", 32'(pix_out_valid), 32'h0);
        @(negedge clk);
        chk("rel_vld3", 32'(pix_out_valid), 32'h1);
        chk("rel_pix3", 32'(pix_out), 32'h5A5);
        pv = 1'b0;

        // Right screen edge: clipped, never wrapped to column 0.
        spr_x[0 +: 10] = 10'd620;
        spr_y[0 +: 9]  = 9'd50;
        spr_en = 4'b0001;
        spr_anim_en = '0;
        tint_en = 1'b1;
        pulse(1'b0);
        add(1, 639, 50, 12'h0A0, 19, EXP_EDGE);
        add(1, 0,   50, 12'h0A0, 0,  12'h0A0);
        add(1, 621, 51, 12'h0A0, 48, 12'h0A0);
        add(1, 619, 50, 12'h0A0, 0,  12'h0A0);
        run_q("edge");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
